// File: rtl/ibex_fp_wb_arbiter_pkg.sv
// Shared types for the FP writeback arbiter: holding-buffer states and write-port sources.
package ibex_fp_pkg;

    typedef enum logic {
        FP_BUF_EMPTY,
        FP_BUF_FULL
    } fp_buf_state_e;

    typedef enum logic [1:0] {
        FP_WB_NONE,
        FP_WB_LSU,
        FP_WB_BUF,
        FP_WB_FPU
    } fp_wb_src_e;

    localparam int unsigned FP_NUM_REGS = 32;

endpackage

// File: rtl/ibex_fp_wb_arbiter_if.sv
// Bundles the issue, LSU, FPU and regfile-write signals of the FP writeback arbiter.
interface ibex_fp_wb_arbiter_if #(
    parameter int unsigned DataWidth = 32
) ();

    logic                 issue_valid_i;
    logic [4:0]           issue_rd_i;
    logic                 issue_ren_a_i;
    logic                 issue_ren_b_i;
    logic [4:0]           fp_raddr_a_i;
    logic [4:0]           fp_raddr_b_i;
    logic                 issue_ready_o;
    logic                 lsu_valid_i;
    logic [4:0]           lsu_rd_i;
    logic [DataWidth-1:0] lsu_wdata_i;
    logic                 fpu_valid_i;
    logic                 fpu_ready_o;
    logic [4:0]           fpu_rd_i;
    logic [DataWidth-1:0] fpu_wdata_i;
    logic [4:0]           fp_waddr_a_o;
    logic [DataWidth-1:0] fp_wdata_a_o;
    logic                 fp_we_a_o;
    logic                 fwd_a_o;
    logic                 fwd_b_o;
    logic [DataWidth-1:0] fwd_data_o;
    logic                 err_o;

    modport master (
        output issue_valid_i, issue_rd_i, issue_ren_a_i, issue_ren_b_i,
        output fp_raddr_a_i, fp_raddr_b_i, lsu_valid_i, lsu_rd_i, lsu_wdata_i,
        output fpu_valid_i, fpu_rd_i, fpu_wdata_i,
        input  issue_ready_o, fpu_ready_o, fp_waddr_a_o, fp_wdata_a_o, fp_we_a_o,
        input  fwd_a_o, fwd_b_o, fwd_data_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_ren_a_i, issue_ren_b_i,
        input  fp_raddr_a_i, fp_raddr_b_i, lsu_valid_i, lsu_rd_i, lsu_wdata_i,
        input  fpu_valid_i, fpu_rd_i, fpu_wdata_i,
        output issue_ready_o, fpu_ready_o, fp_waddr_a_o, fp_wdata_a_o, fp_we_a_o,
        output fwd_a_o, fwd_b_o, fwd_data_o, err_o
    );

endinterface

// File: rtl/ibex_fp_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for the FP register file; stalls issue on RAW/WAW hazards.
module ibex_fp_scoreboard
    import ibex_fp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       issue_valid_i,
    input  logic [4:0] issue_rd_i,
    input  logic       ren_a_i,
    input  logic       ren_b_i,
    input  logic [4:0] raddr_a_i,
    input  logic [4:0] raddr_b_i,
    input  logic       fwd_a_i,
    input  logic       fwd_b_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_rd_i,
    output logic       issue_ready_o,
    output logic       clr_pending_o
);

    logic [FP_NUM_REGS-1:0] pending_q, pending_d;
    logic raw_a, raw_b, waw, set_en;

    // A bypassed operand is satisfied by this cycle's write data.
    assign raw_a         = ren_a_i && pending_q[raddr_a_i] && !fwd_a_i;
    assign raw_b         = ren_b_i && pending_q[raddr_b_i] && !fwd_b_i;
    assign waw           = pending_q[issue_rd_i];
    assign issue_ready_o = !(raw_a || raw_b || waw);
    assign set_en        = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0);
    assign clr_pending_o = pending_q[clr_rd_i];

    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_rd_i] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/ibex_fp_wb_arbiter.sv
// FP writeback arbiter: LSU > buffered FPU > direct FPU onto the single regfile write port.
// Define IBEX_FP_WB_BYPASS_EN to forward this cycle's write data to same-register reads.
module ibex_fp_wb_arbiter
    import ibex_fp_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          WrenCheck = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ibex_fp_wb_arbiter_if.slave   bus
);

    fp_buf_state_e        state_q, state_d;
    fp_wb_src_e           src;
    logic                 buf_load;
    logic [4:0]           buf_rd_q;
    logic [DataWidth-1:0] buf_data_q;
    logic [4:0]           wr_rd;
    logic [DataWidth-1:0] wr_data;
    logic                 we;
    logic                 fwd_a, fwd_b;
    logic                 clr_pending;
    logic                 err_q, err_d;

    always_comb begin
        state_d          = state_q;
        src              = FP_WB_NONE;
        buf_load         = 1'b0;
        bus.fpu_ready_o  = 1'b0;
        unique case (state_q)
            FP_BUF_EMPTY: begin
                bus.fpu_ready_o = 1'b1;
                if (bus.lsu_valid_i) begin
                    src = FP_WB_LSU;
                    if (bus.fpu_valid_i) begin
                        buf_load = 1'b1;
                        state_d  = FP_BUF_FULL;
                    end
                end else if (bus.fpu_valid_i) begin
                    src = FP_WB_FPU;
                end
            end
            FP_BUF_FULL: begin
                if (bus.lsu_valid_i) begin
                    src = FP_WB_LSU;
                end else begin
                    src     = FP_WB_BUF;
                    state_d = FP_BUF_EMPTY;
                end
            end
            default: state_d = FP_BUF_EMPTY;
        endcase
    end

    always_comb begin
        wr_rd   = 5'd0;
        wr_data = '0;
        unique case (src)
            FP_WB_LSU: begin
                wr_rd   = bus.lsu_rd_i;
                wr_data = bus.lsu_wdata_i;
            end
            FP_WB_BUF: begin
                wr_rd   = buf_rd_q;
                wr_data = buf_data_q;
            end
            FP_WB_FPU: begin
                wr_rd   = bus.fpu_rd_i;
                wr_data = bus.fpu_wdata_i;
            end
            default: ;
        endcase
    end

    // rd==0 writes still consume their source but never reach the regfile.
    assign we               = (src != FP_WB_NONE) && (wr_rd != 5'd0);
    assign bus.fp_we_a_o    = we;
    assign bus.fp_waddr_a_o = wr_rd;
    assign bus.fp_wdata_a_o = wr_data;
    assign bus.fwd_data_o   = wr_data;

`ifdef IBEX_FP_WB_BYPASS_EN
    assign fwd_a = we && (wr_rd == bus.fp_raddr_a_i) && (bus.fp_raddr_a_i != 5'd0);
    assign fwd_b = we && (wr_rd == bus.fp_raddr_b_i) && (bus.fp_raddr_b_i != 5'd0);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif
    assign bus.fwd_a_o = fwd_a;
    assign bus.fwd_b_o = fwd_b;

    ibex_fp_scoreboard u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (bus.issue_valid_i),
        .issue_rd_i    (bus.issue_rd_i),
        .ren_a_i       (bus.issue_ren_a_i),
        .ren_b_i       (bus.issue_ren_b_i),
        .raddr_a_i     (bus.fp_raddr_a_i),
        .raddr_b_i     (bus.fp_raddr_b_i),
        .fwd_a_i       (fwd_a),
        .fwd_b_i       (fwd_b),
        .clr_en_i      (we),
        .clr_rd_i      (wr_rd),
        .issue_ready_o (bus.issue_ready_o),
        .clr_pending_o (clr_pending)
    );

    assign err_d     = WrenCheck && we && !clr_pending;
    assign bus.err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= FP_BUF_EMPTY;
            buf_rd_q   <= 5'd0;
            buf_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (buf_load) begin
                buf_rd_q   <= bus.fpu_rd_i;
                buf_data_q <= bus.fpu_wdata_i;
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_ibex_fp_wb_arbiter.sv
// Directed bench for ibex_fp_wb_arbiter (WrenCheck=1); bypass expectations follow IBEX_FP_WB_BYPASS_EN.
module tb_ibex_fp_wb_arbiter;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rf [32];

    always #5 clk_i = ~clk_i;

    ibex_fp_wb_arbiter_if #(.DataWidth(32)) bus ();

    ibex_fp_wb_arbiter #(
        .DataWidth (32),
        .WrenCheck (1'b1)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Regfile model fed by the write port, to observe committed data.
    always @(posedge clk_i) begin
        if (bus.fp_we_a_o) rf[bus.fp_waddr_a_o] <= bus.fp_wdata_a_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.issue_valid_i = 0; bus.issue_rd_i = 0; bus.issue_ren_a_i = 0; bus.issue_ren_b_i = 0;
        bus.fp_raddr_a_i = 0; bus.fp_raddr_b_i = 0;
        bus.lsu_valid_i = 0; bus.lsu_rd_i = 0; bus.lsu_wdata_i = 0;
        bus.fpu_valid_i = 0; bus.fpu_rd_i = 0; bus.fpu_wdata_i = 0;
        step(); step();
        rst_ni = 1'b1;
        #1;
        check("rst_we", bus.fp_we_a_o, 0);
        check("rst_fpu_ready", bus.fpu_ready_o, 1);
        check("rst_err", bus.err_o, 0);
        check("rst_issue_ready", bus.issue_ready_o, 1);
        check("rst_fwd_a", bus.fwd_a_o, 0);

        // 1: issue f5, FPU writes f5
        bus.issue_valid_i = 1; bus.issue_rd_i = 5;
        #1 check("t1_issue_ready", bus.issue_ready_o, 1);
        step();
        bus.issue_valid_i = 0;
        #1 check("t1_pending5_set", bus.issue_ready_o, 0);
        bus.fpu_valid_i = 1; bus.fpu_rd_i = 5; bus.fpu_wdata_i = 32'h3F800000;
        #1;
        check("t1_we", bus.fp_we_a_o, 1);
        check("t1_waddr", bus.fp_waddr_a_o, 5);
        check("t1_wdata", bus.fp_wdata_a_o, 32'h3F800000);
        check("t1_fpu_ready", bus.fpu_ready_o, 1);
        step();
        bus.fpu_valid_i = 0;
        #1;
        check("t1_pending5_clr", bus.issue_ready_o, 1);
        check("t1_rf5", rf[5], 32'h3F800000);
        check("t1_err", bus.err_o, 0);

        // 2: LSU and FPU collide
        bus.issue_valid_i = 1; bus.issue_rd_i = 3;
        step();
        bus.issue_rd_i = 7;
        step();
        bus.issue_valid_i = 0;
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 3; bus.lsu_wdata_i = 32'h40000000;
        bus.fpu_valid_i = 1; bus.fpu_rd_i = 7; bus.fpu_wdata_i = 32'h40400000;
        #1;
        check("t2_c0_waddr", bus.fp_waddr_a_o, 3);
        check("t2_c0_wdata", bus.fp_wdata_a_o, 32'h40000000);
        check("t2_c0_fpu_ready", bus.fpu_ready_o, 1);
        step();
        bus.lsu_valid_i = 0; bus.fpu_valid_i = 0;
        #1;
        check("t2_c1_fpu_ready", bus.fpu_ready_o, 0);
        check("t2_c1_we", bus.fp_we_a_o, 1);
        check("t2_c1_waddr", bus.fp_waddr_a_o, 7);
        check("t2_c1_wdata", bus.fp_wdata_a_o, 32'h40400000);
        step();
        check("t2_c2_fpu_ready", bus.fpu_ready_o, 1);
        check("t2_c2_we", bus.fp_we_a_o, 0);
        check("t2_rf3", rf[3], 32'h40000000);
        check("t2_rf7", rf[7], 32'h40400000);
        check("t2_err", bus.err_o, 0);

        // 3: RAW on f4
        bus.issue_valid_i = 1; bus.issue_rd_i = 4;
        step();
        bus.issue_rd_i = 0; bus.issue_ren_a_i = 1; bus.fp_raddr_a_i = 4;
        #1 check("t3_raw_stall0", bus.issue_ready_o, 0);
        step();
        check("t3_raw_stall1", bus.issue_ready_o, 0);
        bus.fpu_valid_i = 1; bus.fpu_rd_i = 4; bus.fpu_wdata_i = 32'h11111111;
        #1;
        check("t3_fwd_data", bus.fwd_data_o, 32'h11111111);
        check("t3_fwd_b", bus.fwd_b_o, 0);
`ifdef IBEX_FP_WB_BYPASS_EN
        check("t3_wcyc_ready", bus.issue_ready_o, 1);
        check("t3_wcyc_fwd_a", bus.fwd_a_o, 1);
`else
        check("t3_wcyc_ready", bus.issue_ready_o, 0);
        check("t3_wcyc_fwd_a", bus.fwd_a_o, 0);
`endif
        step();
        bus.fpu_valid_i = 0;
        #1;
        check("t3_after_ready", bus.issue_ready_o, 1);
        check("t3_after_fwd_a", bus.fwd_a_o, 0);
        step();
        bus.issue_valid_i = 0; bus.issue_ren_a_i = 0; bus.fp_raddr_a_i = 0;

        // 4: issue f9 with a same-cycle (unexpected) write of f9
        bus.issue_valid_i = 1; bus.issue_rd_i = 9;
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 9; bus.lsu_wdata_i = 32'hA5A5A5A5;
        #1;
        check("t4_ready", bus.issue_ready_o, 1);
        check("t4_waddr", bus.fp_waddr_a_o, 9);
        step();
        bus.lsu_valid_i = 0;
        #1;
        check("t4_waw_stall", bus.issue_ready_o, 0);
        check("t4_err", bus.err_o, 1);
        bus.issue_valid_i = 0;
        bus.fpu_valid_i = 1; bus.fpu_rd_i = 9; bus.fpu_wdata_i = 32'h5A5A5A5A;
        #1 check("t4_drain_we", bus.fp_we_a_o, 1);
        step();
        bus.fpu_valid_i = 0;
        #1;
        check("t4_drain_err", bus.err_o, 0);
        check("t4_drain_ready", bus.issue_ready_o, 1);

        // 5: rd==0 write, then unexpected LSU write
        bus.fpu_valid_i = 1; bus.fpu_rd_i = 0; bus.fpu_wdata_i = 32'hDEADBEEF;
        #1;
        check("t5_rd0_we", bus.fp_we_a_o, 0);
        check("t5_rd0_fpu_ready", bus.fpu_ready_o, 1);
        step();
        bus.fpu_valid_i = 0;
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 6; bus.lsu_wdata_i = 32'h12345678;
        #1;
        check("t5_rd0_err", bus.err_o, 0);
        check("t5_lsu_we", bus.fp_we_a_o, 1);
        step();
        bus.lsu_valid_i = 0;
        #1 check("t5_err_high", bus.err_o, 1);
        step();
        check("t5_err_low", bus.err_o, 0);

        // 6: reset with buffer full and pending bits set
        bus.issue_valid_i = 1; bus.issue_rd_i = 12;
        step();
        bus.issue_rd_i = 13;
        step();
        bus.issue_valid_i = 0;
        bus.lsu_valid_i = 1; bus.lsu_rd_i = 12; bus.lsu_wdata_i = 32'h0000000C;
        bus.fpu_valid_i = 1; bus.fpu_rd_i = 13; bus.fpu_wdata_i = 32'h0000000D;
        step();
        bus.lsu_valid_i = 0; bus.fpu_valid_i = 0;
        #1 check("t6_full", bus.fpu_ready_o, 0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        check("t6_empty", bus.fpu_ready_o, 1);
        check("t6_we", bus.fp_we_a_o, 0);
        check("t6_err", bus.err_o, 0);
        bus.issue_rd_i = 12;
        #1 check("t6_pending12", bus.issue_ready_o, 1);
        bus.issue_rd_i = 13;
        #1 check("t6_pending13", bus.issue_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
